// File: rtl/nmcu_desc_fetch_if.sv
// rtl/nmcu_desc_fetch_if.sv - memory read bus and descriptor stream between the fetch engine and its neighbours
interface nmcu_desc_fetch_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int IDX_W         = 3
);
  logic                     mem_sel;
  logic                     mem_w;
  logic [ADDR_WIDTH-1:0]    address_bus;
  logic [DATABUS_WIDTH-1:0] mem_rdata;
  logic                     ready;

  logic                     desc_valid;
  logic                     desc_ready;
  logic [1:0]               desc_op;
  logic [15:0]              desc_kaddr;
  logic [2:0]               desc_kdim;
  logic [3:0]               desc_in_w;
  logic [3:0]               desc_in_h;
  logic [IDX_W-1:0]         desc_idx;
  logic                     desc_last;

  modport master (
    output mem_sel, mem_w, address_bus,
    input  mem_rdata, ready,
    output desc_valid, desc_op, desc_kaddr, desc_kdim, desc_in_w, desc_in_h, desc_idx, desc_last,
    input  desc_ready
  );

  modport slave (
    input  mem_sel, mem_w, address_bus,
    output mem_rdata, ready,
    input  desc_valid, desc_op, desc_kaddr, desc_kdim, desc_in_w, desc_in_h, desc_idx, desc_last,
    output desc_ready
  );
endinterface

// File: rtl/nmcu_desc_fetch.sv
// rtl/nmcu_desc_fetch.sv - NMCU descriptor list walker with prefetch FIFO; legality checks enabled by NMCU_DESC_CHECK_EN
module nmcu_desc_fetch #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATABUS_WIDTH  = 32,
  parameter int MAX_DESCS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_INPUT_DIM  = 15,
  parameter int MAX_KERNEL_DIM = 7,
  localparam int IDX_W = $clog2(MAX_DESCS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  nmcu_desc_fetch_if.master     bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_CONV = 2'b01;

`ifdef NMCU_DESC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQ, GAP, DRAIN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [15:0]      kaddr;
    logic [2:0]       kdim;
    logic [3:0]       in_w;
    logic [3:0]       in_h;
    logic [IDX_W-1:0] idx;
    logic             last;
  } desc_t;

  state_t                   state, state_n;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [IDX_W-1:0]         idx;
  logic                     err_q;
  desc_t                    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [DATABUS_WIDTH-1:0] rdata;
  logic [31:0]              word;
  desc_t                    fetched, head, head_out;
  logic                     head_valid;
  logic                     chk_bad, chk_fail;
  logic                     req_en, accept, push, pop, flush, fetch_fail;

  assign rdata = bus.mem_rdata;
  assign word  = rdata[31:0];

  always_comb begin
    fetched       = '0;
    fetched.kaddr = word[31:16];
    fetched.kdim  = word[12:10];
    fetched.in_w  = word[9:6];
    fetched.in_h  = word[5:2];
    fetched.op    = word[1:0];
    fetched.idx   = idx;
    fetched.last  = (word[1:0] == OP_NOP) || (idx == IDX_W'(MAX_DESCS - 1));
  end

  // Legality of the word on the bus; only acted on when checking is compiled in.
  always_comb begin
    chk_bad = (word[15:13] != 3'b000)
           || (fetched.in_w == 4'd0) || (int'(fetched.in_w) > MAX_INPUT_DIM)
           || (fetched.in_h == 4'd0) || (int'(fetched.in_h) > MAX_INPUT_DIM);
    if (fetched.op == OP_CONV &&
        (fetched.kdim == 3'd0 || int'(fetched.kdim) > MAX_KERNEL_DIM ||
         {1'b0, fetched.kdim} > fetched.in_w || {1'b0, fetched.kdim} > fetched.in_h))
      chk_bad = 1'b1;
  end

  assign chk_fail = CHECK_EN && chk_bad;

  assign head_valid = (count != '0);
  assign head       = fifo_mem[rd_ptr];
  assign head_out   = head_valid ? head : '0;
  assign pop        = head_valid && bus.desc_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_en     = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    fetch_fail = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // Request is withheld while the FIFO is full; once raised it holds until ready.
        req_en = (count < CNT_W'(FIFO_DEPTH));
        if (req_en && bus.ready) begin
          if (chk_fail) begin
            fetch_fail = 1'b1;
            state_n    = FLUSH;
          end else begin
            push    = 1'b1;
            state_n = fetched.last ? DRAIN : GAP;
          end
        end
      end
      GAP:   state_n = REQ;
      DRAIN: if (pop && head.last) state_n = DONE;
      FLUSH: begin
        flush   = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        idx    <= '0;
        err_q  <= 1'b0;
      end
      if (push)       idx   <= idx + IDX_W'(1);
      if (fetch_fail) err_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fetched;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;

  assign bus.mem_sel     = req_en;
  assign bus.mem_w       = 1'b0;
  assign bus.address_bus = req_en ? (base_q + ADDR_WIDTH'(idx)) : '0;

  assign bus.desc_valid  = head_valid;
  assign bus.desc_op     = head_out.op;
  assign bus.desc_kaddr  = head_out.kaddr;
  assign bus.desc_kdim   = head_out.kdim;
  assign bus.desc_in_w   = head_out.in_w;
  assign bus.desc_in_h   = head_out.in_h;
  assign bus.desc_idx    = head_out.idx;
  assign bus.desc_last   = head_out.last;
endmodule

// File: doc/nmcu_desc_fetch.md
# nmcu_desc_fetch

Descriptor fetch engine for the next-generation NMCU: on `start` it walks a descriptor list in memory over the shared `mem` bus and prefetches descriptors into a parametrised FIFO. It decodes each 32-bit word into fields and hands them to the compute datapath over a valid/ready interface, so descriptor fetch overlaps computation. The list ends on a NOP descriptor or after `MAX_DESCS` entries, with optional legality checking. It sits between the NMCU control port (`start`/`done`) and the CONV/RELU/MAXP datapath.

## Interface
- `ADDR_WIDTH`, 16: memory address width.
- `DATABUS_WIDTH`, 32: memory data width; must be ≥32; descriptor occupies bits [31:0].
- `MAX_DESCS`, 8: hard list-length limit.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `MAX_INPUT_DIM`, 15: largest legal input width/height.
- `MAX_KERNEL_DIM`, 7: largest legal kernel dimension.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; honoured only when idle.
- `base_addr`  in  ADDR_WIDTH  address of descriptor 0; latched on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky illegal-descriptor flag; cleared on accepted `start`.
- `mem_sel`  out  1  memory request.
- `mem_w`  out  1  always 0 (read-only master).
- `address_bus`  out  ADDR_WIDTH  request address; 0 when `mem_sel` is low.
- `mem_rdata`  in  DATABUS_WIDTH  read data; sampled when `ready` is high.
- `ready`  in  1  memory completion strobe.
- `desc_valid`  out  1  FIFO head valid.
- `desc_ready`  in  1  consumer accepts head.
- `desc_op`  out  2  00 NOP, 01 CONV, 10 MAXP, 11 RELU.
- `desc_kaddr`  out  16  kernel address.
- `desc_kdim`  out  3  kernel dimension.
- `desc_in_w`, `desc_in_h`  out  4 each  input width/height.
- `desc_idx`  out  $clog2(MAX_DESCS)  list index of head.
- `desc_last`  out  1  head is the final descriptor.

## Operation
- Word layout: [31:16] kaddr, [15:13] reserved, [12:10] kdim, [9:6] in_w, [5:2] in_h, [1:0] op.
- FSM states: IDLE, REQ, GAP, DRAIN, FLUSH, DONE.
- IDLE: an accepted `start` latches `base_addr`, clears idx and `err`, and goes to REQ. `start` in any other state is ignored; `base_addr` changes after latch have no effect.
- REQ: issues a read only if the FIFO count is below `FIFO_DEPTH`. Drives `mem_sel`=1 and `address_bus`=base+idx, held stable until `ready`. In the `ready` cycle the word is captured and pushed, idx increments, and the FSM goes to GAP.
- Termination: a pushed word with op=NOP, or with idx=`MAX_DESCS`-1, is tagged `desc_last`, and the FSM goes to DRAIN. GAP otherwise returns to REQ.
- DRAIN: no further reads. On the handshake of the `desc_last` entry, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Check failure in the `ready` cycle: the word is not pushed, `err` is set, and the FSM goes to FLUSH. FLUSH empties the FIFO in one cycle, then goes to DONE.
- FIFO: push and pop in the same cycle are both allowed, count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Address: base+idx, truncated to `ADDR_WIDTH`, wraps silently.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_sel`, `mem_w`, `desc_valid`, `desc_last` = 0; `address_bus` and all `desc_*` fields = 0. FIFO is emptied and the FSM goes to IDLE, immediately on reset assertion regardless of state.
- `start` in cycle 0 → `mem_sel` high in cycle 1.
- `mem_sel` drops the cycle after `ready`. It stays low exactly one cycle (GAP) before the next request.
- A word pushed in the `ready` cycle appears with `desc_valid`=1 in the next cycle.
- While `desc_valid`=1 and `desc_ready`=0, all `desc_*` outputs are stable.
- `done` asserts the cycle after the last handshake. `desc_valid` is 0 in the `done` cycle.
- Throughput with memory latency L and no backpressure: one descriptor per L+2 cycles.

## Configuration
- `NMCU_DESC_CHECK_EN` defined: every fetched word is checked. It fails when:
  - reserved bits ≠0;
  - in_w or in_h is 0 or > `MAX_INPUT_DIM`;
  - op=CONV with kdim 0, kdim > `MAX_KERNEL_DIM`, or kdim > in_w/in_h.
- Undefined: no checks, `err` is tied 0, and FLUSH is unreachable.

## Test plan
- Memory at 0..3 = 0x12340D11, 0x0000008B, 0x0000008A, 0x00000044; base 0, memory LATENCY 2, `desc_ready`=1 → four handshakes with op 1,3,2,0. First: kaddr 0x1234, kdim 3, w 4, h 4. `desc_last` set only on idx 3; one `done`; `err`=0; address 4 never requested.
- Eight CONV-free words (0x8B) with no NOP, `desc_ready`=0 for 60 cycles → exactly 4 reads issued. Release → idx 0..7 delivered in order, `desc_last` on idx 7, address 8 never requested.
- Word 0 = 0x12340111 (CONV, kdim 0). With macro: no `desc_valid`, `err`=1 and `done` pulse. Without macro: delivered as kdim 0, `err`=0.
- `rst` low while `mem_sel`=1 → `mem_sel`, `busy`, `desc_valid` = 0 immediately. After release, a new `start` runs the first scenario correctly.
- Second `start` and a `base_addr` change mid-run → ignored; results identical to the first scenario.
- Toggle `desc_ready` every cycle over the first scenario → same four descriptors, no duplicates or drops, fields stable during stalls.
